reset_sequencer: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/reset_sync.sv | 24 ++
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM states and counter sizing.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        WAIT_DONE,
        READY,
        FAULT
    } seq_state_t;

    // The one counter times both the settle delay and the acknowledge
    // timeout, so it must hold the larger of the two without wrapping.
    function automatic int cnt_width(input int delay_cycles, input int timeout_cycles);
        int largest;
        largest = (delay_cycles > timeout_cycles) ? delay_cycles : timeout_cycles;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser.
// Any clock domain can reuse it to get a glitch-free release of a reset.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_in,
    output logic rst_out
);

    logic [SYNC_STAGES-1:0] chain;

    // Assert at once on rst_in, then shift zeros in so release takes SYNC_STAGES edges.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains one at a time after the
// incoming reset has been re-synchronised. Each release follows a settle
// delay and, for stages selected in DONE_MASK, waits for that stage's
// done level under a timeout. A timeout re-asserts every stage and latches
// the failing stage index until the next reset.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int                    NUM_STAGES  = 4,
    parameter int                    STAGE_DELAY = 1000,
    parameter int                    TIMEOUT     = 100000,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [NUM_STAGES-1:0] DONE_MASK   = '1
) (
    input  logic                  clk_100m,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  sys_ready,
    output logic                  timeout_err,
    output logic [3:0]            err_stage
);

    localparam int CW    = cnt_width(STAGE_DELAY, TIMEOUT);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    // Terminal counts: the transition fires on the edge where the counter
    // already holds the last value, so the state lasts exactly N edges.
    localparam logic [CW-1:0]    DELAY_LAST   = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

    logic                  rst_sync;
    seq_state_t            state, next_state;
    logic [CW-1:0]         cnt, next_cnt;
    logic [IDX_W-1:0]      idx, next_idx;
    logic [NUM_STAGES-1:0] next_stage_rst;
    logic                  next_sys_ready;
    logic                  next_timeout_err;
    logic [3:0]            next_err_stage;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk     (clk_100m),
        .rst_in  (reset),
        .rst_out (rst_sync)
    );

    // State, counter, stage index and every output are registered here, so
    // stage_done never reaches an output combinationally.
    always_ff @(posedge clk_100m or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            stage_rst   <= '1;
            sys_ready   <= 1'b0;
            timeout_err <= 1'b0;
            err_stage   <= 4'd0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            idx         <= next_idx;
            stage_rst   <= next_stage_rst;
            sys_ready   <= next_sys_ready;
            timeout_err <= next_timeout_err;
            err_stage   <= next_err_stage;
        end
    end

    // Sequencing decisions: settle, release, optionally await done, advance.
    always_comb begin
        next_state       = state;
        next_cnt         = cnt;
        next_idx         = idx;
        next_stage_rst   = stage_rst;
        next_sys_ready   = sys_ready;
        next_timeout_err = timeout_err;
        next_err_stage   = err_stage;

        case (state)
            IDLE: begin
                if (!rst_sync) begin
                    next_state = DELAY;
                    next_cnt   = '0;
                    next_idx   = '0;
                end
            end

            DELAY: begin
                if (cnt == DELAY_LAST) begin
                    next_stage_rst[idx] = 1'b0;
                    next_cnt            = '0;
                    if (DONE_MASK[idx]) begin
                        next_state = WAIT_DONE;
                    end else if (idx == LAST_IDX) begin
                        next_state     = READY;
                        next_sys_ready = 1'b1;
                    end else begin
                        next_state = DELAY;
                        next_idx   = idx + 1'b1;
                    end
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                // done is tested before the timeout so a coincident ack wins
                if (stage_done[idx]) begin
                    next_cnt = '0;
                    if (idx == LAST_IDX) begin
                        next_state     = READY;
                        next_sys_ready = 1'b1;
                    end else begin
                        next_state = DELAY;
                        next_idx   = idx + 1'b1;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state       = FAULT;
                    next_cnt         = '0;
                    next_stage_rst   = '1;
                    next_sys_ready   = 1'b0;
                    next_timeout_err = 1'b1;
                    next_err_stage   = 4'(idx);
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end

            READY: begin
                next_state = READY;
            end

            FAULT: begin
                next_state = FAULT;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer. Expected output words are built
// from the edge-numbered release/fault times and queued before each run;
// they are popped and compared as the run reaches each edge.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic [2:0] done_a;
    logic [2:0] done_b;
    logic [2:0] stage_rst_a, stage_rst_b;
    logic       sys_ready_a, sys_ready_b;
    logic       timeout_err_a, timeout_err_b;
    logic [3:0] err_stage_a, err_stage_b;
    logic       sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         edge_no;
        logic [8:0] exp;
    } exp_t;

    exp_t sb_q[$];

    localparam int NEVER = 100000;

    reset_sequencer #(
        .NUM_STAGES (3),
        .STAGE_DELAY(4),
        .TIMEOUT    (10),
        .SYNC_STAGES(2),
        .DONE_MASK  (3'b111)
    ) dut_a (
        .clk_100m   (clk),
        .reset      (reset),
        .stage_done (done_a),
        .stage_rst  (stage_rst_a),
        .sys_ready  (sys_ready_a),
        .timeout_err(timeout_err_a),
        .err_stage  (err_stage_a)
    );

    reset_sequencer #(
        .NUM_STAGES (3),
        .STAGE_DELAY(4),
        .TIMEOUT    (10),
        .SYNC_STAGES(2),
        .DONE_MASK  (3'b110)
    ) dut_b (
        .clk_100m   (clk),
        .reset      (reset),
        .stage_done (done_b),
        .stage_rst  (stage_rst_b),
        .sys_ready  (sys_ready_b),
        .timeout_err(timeout_err_b),
        .err_stage  (err_stage_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] sampleOutputs();
        if (sel)
            return {stage_rst_b, sys_ready_b, timeout_err_b, err_stage_b};
        return {stage_rst_a, sys_ready_a, timeout_err_a, err_stage_a};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Queue the expected output word for edges 1..n_edges given the edge at
    // which each stage releases, sys_ready rises, and a fault (if any) lands.
    task automatic pushSeq(input int n_edges, input int f0, input int f1, input int f2,
                           input int rdy_edge, input int fault_edge, input logic [3:0] fault_stage);
        exp_t       item;
        logic [2:0] r;
        logic       rdy, terr;
        logic [3:0] es;
        for (int e = 1; e <= n_edges; e++) begin
            r    = 3'b111;
            if (e >= f0) r[0] = 1'b0;
            if (e >= f1) r[1] = 1'b0;
            if (e >= f2) r[2] = 1'b0;
            rdy  = (e >= rdy_edge);
            terr = 1'b0;
            es   = 4'd0;
            if (e >= fault_edge) begin
                r    = 3'b111;
                rdy  = 1'b0;
                terr = 1'b1;
                es   = fault_stage;
            end
            item.edge_no = e;
            item.exp     = {r, rdy, terr, es};
            sb_q.push_back(item);
        end
    endtask

    task automatic drainAt(input string tag, input int e);
        exp_t item;
        while (sb_q.size() > 0 && sb_q[0].edge_no == e) begin
            item = sb_q.pop_front();
            checkOutput($sformatf("%s_e%0d", tag, e), {23'd0, sampleOutputs()}, {23'd0, item.exp});
        end
    endtask

    // Assert reset between edges and verify the outputs clear without a clock.
    task automatic resetCheck(input string tag);
        exp_t item;
        #2 reset = 1'b1;
        #1;
        item.edge_no = 0;
        item.exp     = {3'b111, 1'b0, 1'b0, 4'd0};
        sb_q.push_back(item);
        drainAt(tag, 0);
    endtask

    // Release reset just before edge 1 and step through n_edges edges,
    // optionally raising extra done bits after a given edge.
    task automatic applyStimulus(input string tag, input int n_edges,
                                 input int raise_edge, input logic [2:0] raise_mask);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge clk);
            #1;
            drainAt(tag, e);
            if (e == raise_edge) done_a = done_a | raise_mask;
        end
        checkOutput({tag, "_leftover"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        reset  = 1'b1;
        done_a = 3'b000;
        done_b = 3'b110;
        sel    = 1'b0;
        #23;
        resetCheck("rst_init_a");
        sel = 1'b1;
        resetCheck("rst_init_b");
        sel = 1'b0;

        $display("[TB] nominal sequence");
        done_a = 3'b111;
        pushSeq(20, 7, 12, 17, 18, NEVER, 4'd0);
        applyStimulus("nominal", 20, 0, 3'b000);
        resetCheck("rst_after_nominal");

        $display("[TB] timeout on stage 0");
        done_a = 3'b000;
        pushSeq(67, 7, NEVER, NEVER, NEVER, 17, 4'd0);
        applyStimulus("timeout0", 67, 0, 3'b000);
        resetCheck("rst_after_timeout0");

        $display("[TB] timeout on stage 1 then reset from fault");
        done_a = 3'b001;
        pushSeq(25, 7, 12, NEVER, NEVER, 22, 4'd1);
        applyStimulus("timeout1", 25, 0, 3'b000);
        resetCheck("rst_from_fault");
        done_a = 3'b111;
        pushSeq(20, 7, 12, 17, 18, NEVER, 4'd0);
        applyStimulus("after_fault", 20, 0, 3'b000);
        resetCheck("rst_after_recovery");

        $display("[TB] reset mid-sequence");
        pushSeq(13, 7, 12, 17, 18, NEVER, 4'd0);
        applyStimulus("mid_seq", 13, 0, 3'b000);
        resetCheck("rst_mid_seq");
        pushSeq(20, 7, 12, 17, 18, NEVER, 4'd0);
        applyStimulus("restart", 20, 0, 3'b000);
        resetCheck("rst_after_restart");

        $display("[TB] done mask skip");
        sel = 1'b1;
        pushSeq(20, 7, 11, 16, 17, NEVER, 4'd0);
        applyStimulus("mask", 20, 0, 3'b000);
        resetCheck("rst_after_mask");
        sel = 1'b0;

        $display("[TB] late acknowledgement");
        done_a = 3'b101;
        pushSeq(30, 7, 12, 25, 26, NEVER, 4'd0);
        applyStimulus("late9", 30, 20, 3'b010);
        resetCheck("rst_after_late9");

        done_a = 3'b101;
        pushSeq(30, 7, 12, 26, 27, NEVER, 4'd0);
        applyStimulus("late10", 30, 21, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
